truth_table_sweeper: RTL

Synchronous stimulus-and-capture stage placed directly upstream of the 3-input SOP equation circuit (Y = ABC + AB + AC = A(B+C)). It drives the circuit's inputs A, B, C through all 8 combinations, holding each for a programmable dwell so gate delays settle, and samples Y back into an 8-bit truth-table register. On completion it compares the table against an expected value and pulses done. This replaces the hand-written timed input sweep with a clocked, self-checking sequencer.

---
 rtl/truth_table_sweeper.sv | 92 +++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Clocked stimulus/capture sequencer for the 3-input A(B+C) equation circuit:
// walks {a,b,c} through all 8 vectors, samples y per vector and checks the table.
module truth_table_sweeper #(
  parameter int         DWELL  = 4,
  parameter logic [7:0] EXPECT = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [7:0] cnt;
  logic       dwell_end;
  logic       last_vec;
  logic [7:0] table_nxt;

  // Next-state and output decode; outputs depend only on registered state/vec.
  always_comb begin
    state_nxt        = state;
    a                = 1'b0;
    b                = 1'b0;
    c                = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    dwell_end        = (state == RUN) && (cnt == CNT_LAST);
    last_vec         = (vec == 3'd7);
    table_nxt        = table_out;
    table_nxt[vec]   = y;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        {a, b, c} = vec;
        busy      = 1'b1;
        if (dwell_end && last_vec) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sweep counters and capture; pass is judged on the table including the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec       <= 3'd0;
      cnt       <= 8'd0;
      table_out <= 8'h00;
      pass      <= 1'b0;
    end else if (state == IDLE && start) begin
      vec       <= 3'd0;
      cnt       <= 8'd0;
      table_out <= 8'h00;
      pass      <= 1'b0;
    end else if (dwell_end) begin
      table_out <= table_nxt;
      cnt       <= 8'd0;
      if (last_vec) pass <= (table_nxt == EXPECT);
      else          vec  <= vec + 3'd1;
    end else if (state == RUN) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule
